// File: rtl/special_seq_checker.sv
// Receive-side monitor for the 3-bit special counter: tracks the 0->1->3->7->6->4->0
// sequence, acquires/loses lock, counts mismatches and reports wraps.
module special_seq_checker #(
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 3,
  parameter int LOSS_N = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_q_in,
  input  logic             i_q_valid,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_wrap_pulse,
  output logic [2:0]       o_expected
);

  localparam int RUN_MAX = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
  localparam int RUN_W   = $clog2(RUN_MAX) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Illegal codes 2 and 5 map to 0 so expected reads 0 after an illegal sample.
  function automatic logic [2:0] f_next(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'd0:    n = 3'd1;
      3'd1:    n = 3'd3;
      3'd3:    n = 3'd7;
      3'd7:    n = 3'd6;
      3'd6:    n = 3'd4;
      3'd4:    n = 3'd0;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic f_legal(input logic [2:0] c);
    return (c != 3'd2) && (c != 3'd5);
  endfunction

  state_t           r_state;
  logic [2:0]       r_prev;
  logic [RUN_W-1:0] r_good_run;
  logic [RUN_W-1:0] r_bad_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_wrap_pulse;
  logic [2:0]       r_expected;

  logic             w_good;
  logic [RUN_W-1:0] w_good_inc;
  logic [RUN_W-1:0] w_bad_inc;
  logic             w_err_sat;

  // Anything touching an illegal code is a bad transition.
  assign w_good     = f_legal(r_prev) && f_legal(i_q_in) && (i_q_in == f_next(r_prev));
  assign w_good_inc = r_good_run + {{(RUN_W-1){1'b0}}, 1'b1};
  assign w_bad_inc  = r_bad_run + {{(RUN_W-1){1'b0}}, 1'b1};
  assign w_err_sat  = &r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_prev       <= 3'd0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
      r_wrap_pulse <= 1'b0;
      r_expected   <= 3'd0;
    end else begin
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      if (i_q_valid) begin
        r_prev <= i_q_in;
        case (r_state)
          ST_IDLE: begin
            if (f_legal(i_q_in)) begin
              r_state    <= ST_SEARCH;
              r_good_run <= '0;
              r_bad_run  <= '0;
              r_expected <= f_next(i_q_in);
            end else begin
              r_expected <= 3'd0;
            end
          end
          ST_SEARCH: begin
            r_expected <= f_next(i_q_in);
            if (w_good) begin
              if (w_good_inc == RUN_W'(LOCK_N)) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_good_run <= '0;
                r_bad_run  <= '0;
              end else begin
                r_good_run <= w_good_inc;
              end
            end else begin
              r_good_run <= '0;
            end
          end
          ST_LOCKED: begin
            r_expected <= f_next(i_q_in);
            if (w_good) begin
              r_bad_run    <= '0;
              r_wrap_pulse <= (r_prev == 3'd4);
            end else begin
              r_err_pulse <= 1'b1;
              if (!w_err_sat) begin
                r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
              end
              // Enough consecutive misses: fall back and re-acquire from scratch.
              if (w_bad_inc == RUN_W'(LOSS_N)) begin
                r_state    <= ST_SEARCH;
                r_locked   <= 1'b0;
                r_good_run <= '0;
                r_bad_run  <= '0;
              end else begin
                r_bad_run <= w_bad_inc;
              end
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_locked   <= 1'b0;
            r_good_run <= '0;
            r_bad_run  <= '0;
            r_expected <= 3'd0;
          end
        endcase
      end
    end
  end

  assign o_locked     = r_locked;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_cnt    = r_err_cnt;
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_expected   = r_expected;

endmodule

// File: tb/tb_special_seq_checker.sv
// Directed bench for special_seq_checker: default instance plus an ERR_W=2 instance
// sharing stimulus; hand-derived expectations flow through a scoreboard queue.
module tb_special_seq_checker;

  logic       clk;
  logic       rst;
  logic [2:0] q_in;
  logic       q_valid;

  logic       lk_a, ep_a, wp_a;
  logic [7:0] ec_a;
  logic [2:0] ex_a;
  logic       lk_b, ep_b, wp_b;
  logic [1:0] ec_b;
  logic [2:0] ex_b;

  special_seq_checker dut_a (
    .i_clk(clk), .i_rst(rst), .i_q_in(q_in), .i_q_valid(q_valid),
    .o_locked(lk_a), .o_err_pulse(ep_a), .o_err_cnt(ec_a),
    .o_wrap_pulse(wp_a), .o_expected(ex_a)
  );

  special_seq_checker #(.ERR_W(2), .LOCK_N(3), .LOSS_N(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_q_in(q_in), .i_q_valid(q_valid),
    .o_locked(lk_b), .o_err_pulse(ep_b), .o_err_cnt(ec_b),
    .o_wrap_pulse(wp_b), .o_expected(ex_b)
  );

  typedef struct {
    string      tag;
    logic       lk;
    logic       ep;
    logic       wp;
    logic [2:0] ex;
    logic [7:0] ec_a;
    logic [1:0] ec_b;
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   err_model = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_total++;
    assert (obs === want) n_passed++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, want);
  endtask

  // One directed cycle: drive, push expectation, sample #1 after the edge, pop and compare.
  task automatic step(input logic r, input logic v, input logic [2:0] q,
                      input logic lk, input logic ep, input logic wp,
                      input logic [2:0] ex, input string tag);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r; q_valid = v; q_in = q;
    if (r) err_model = 0;
    else if (ep && err_model < 255) err_model++;
    e.tag = tag; e.lk = lk; e.ep = ep; e.wp = wp; e.ex = ex;
    e.ec_a = 8'(err_model);
    e.ec_b = (err_model > 3) ? 2'd3 : 2'(err_model);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({g.tag, ".locked"},    {7'd0, lk_a}, {7'd0, g.lk});
    chk({g.tag, ".err_pulse"}, {7'd0, ep_a}, {7'd0, g.ep});
    chk({g.tag, ".wrap"},      {7'd0, wp_a}, {7'd0, g.wp});
    chk({g.tag, ".expected"},  {5'd0, ex_a}, {5'd0, g.ex});
    chk({g.tag, ".err_cnt"},   ec_a,         g.ec_a);
    chk({g.tag, ".b_err_cnt"}, {6'd0, ec_b}, {6'd0, g.ec_b});
    chk({g.tag, ".b_err_pulse"}, {7'd0, ep_b}, {7'd0, g.ep});
    chk({g.tag, ".b_locked"},  {7'd0, lk_b}, {7'd0, g.lk});
  endtask

  initial begin
    logic [2:0] garbage [5];
    garbage = '{3'd2, 3'd5, 3'd7, 3'd3, 3'd0};
    rst = 1'b1; q_valid = 1'b0; q_in = 3'd0;

    // reset wins over a valid sample
    step(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, "rst");
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, "rst_hold");
    step(1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, "idle_novalid");

    // acquire lock on 0,1,3,7
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, "t1_s0");
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd3, "t1_s1");
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd7, "t1_s3");
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 3'd6, "t1_lock");

    // wrap pulse on 4->0 while locked
    step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 3'd4, "t2_s6");
    step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, "t2_s4");
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, "t2_wrap");
    step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd3, "t2_s1");

    // illegal code then bad exit: two errors, lock lost, then relock
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd7, "t3_s3");
    step(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0, "t3_bad2");
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 3'd4, "t3_drop");
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, "t3_s4");
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, "t3_s0_nowrap");
    step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd3, "t3_relock");

    // stall 7->7 is one error; 7->6 clears the bad run
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd7, "t4_s3");
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 3'd6, "t4_s7");
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 3'd6, "t4_stall");
    step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 3'd4, "t4_s6");
    step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, "t4_s4");

    // q_valid low with garbage: nothing moves
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, garbage[i], 1'b1, 1'b0, 1'b0, 3'd0, "t5_gap");
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, "t5_resume_wrap");
    step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd3, "t5_s1");

    // bad run survives a valid gap; ERR_W=2 copy saturates at 3
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd7, "t6_s3");
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd7, "t6_repeat");
    step(1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd7, "t6_gap0");
    step(1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd7, "t6_gap1");
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, "t6_drop_sat");
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 3'd6, "t6_out_of_illegal");
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd4, "t6_s6");
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, "t6_s4");
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd1, "t6_relock_nowrap");

    // reset mid-operation, then illegal codes never seed the checker
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, "rst_mid");
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, "idle_ill5");
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, "idle_ill2");
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, "r2_s0");
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd3, "r2_s1");
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd7, "r2_s3");
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 3'd6, "r2_lock");
    step(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, "rst_end");

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
